// File: rtl/aes128_iter_ecb_ctr_if.sv
// Block-stream interface for the iterative AES-128 engine.
// Carries the input block handshake (in_valid/in_ready/in_data) and the
// result handshake (out_valid/out_ready/out_data).
//   master : host side; drives in_valid, in_data and out_ready
//   slave  : engine side; drives in_ready, out_valid and out_data
interface aes128_iter_ecb_ctr_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes128_iter_ecb_ctr.sv
// Iterative AES-128 encryption engine, one round per clock.
// Runtime ECB / CTR selection, key and IV capture while idle, and
// valid/ready flow control on both the block input and the result.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   key_load, key     capture cipher key (FIPS-197 byte order) while idle
//   iv_load, iv       capture initial counter block while idle
//   mode              0 = ECB, 1 = CTR; sampled when a block is accepted
//   bus (slave)       in_valid/in_ready/in_data, out_valid/out_ready/out_data
//   ctr_value         current counter register
//   busy              engine is not idle

// Combinational FIPS-197 S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes128_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = '0;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p ^= xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = x^(2+4+...+128); maps 0 to 0 as the S-box requires.
    always_comb begin
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes128_iter_ecb_ctr #(
    parameter int NR        = 10,
    parameter int CTR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_load,
    input  logic [127:0]          key,
    input  logic                  iv_load,
    input  logic [127:0]          iv,
    input  logic                  mode,
    aes128_iter_ecb_ctr_if.slave  bus,
    output logic [127:0]          ctr_value,
    output logic                  busy
);
    localparam int RW = $clog2(NR + 1);
    // Low CTR_WIDTH bits of the counter take part in the increment.
    localparam logic [127:0] CMASK = (128'd1 << CTR_WIDTH) - 128'd1;

    typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_t;

    state_t          fsm, fsm_nxt;
    logic [127:0]    key_reg, ctr, st, rkey, din_l, out_q;
    logic            mode_l;
    logic [RW-1:0]   rnd;
    logic            accept, last;

    logic [127:0]    sub, sr, mc, nk, rnd_out;
    logic [31:0]     kw_rot, kw_sub;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [RW-1:0] r);
        case (int'(r))
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign accept = bus.in_valid & bus.in_ready;
    assign last   = (rnd == RW'(NR));

    // ---- round datapath ----
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes128_sbox u_sb (.a(st[127-8*i -: 8]), .y(sub[127-8*i -: 8]));
    end

    // RotWord of the last key word, then SubWord.
    assign kw_rot = {rkey[23:0], rkey[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes128_sbox u_sb (.a(kw_rot[31-8*i -: 8]), .y(kw_sub[31-8*i -: 8]));
    end

    always_comb begin
        logic [31:0] k0, k1, k2, k3;
        k0 = rkey[127:96] ^ kw_sub ^ {rcon(rnd), 24'h0};
        k1 = rkey[95:64]  ^ k0;
        k2 = rkey[63:32]  ^ k1;
        k3 = rkey[31:0]   ^ k2;
        nk = {k0, k1, k2, k3};
    end

    always_comb begin
        sr = '0;
        mc = '0;
        // Byte (row r, col c) takes the byte from col (c+r) mod 4 of the same row.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
        rnd_out = (last ? sr : mc) ^ nk;
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (accept)        fsm_nxt = ROUND;
            ROUND:   if (last)          fsm_nxt = HOLD;
            HOLD:    if (bus.out_ready) fsm_nxt = IDLE;
            default:                    fsm_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        bus.in_ready  = (fsm == IDLE) & ~key_load & ~iv_load;
        bus.out_valid = (fsm == HOLD);
        busy          = (fsm != IDLE);
    end

    assign bus.out_data = out_q;
    assign ctr_value    = ctr;

    // ---- datapath registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
            ctr     <= '0;
            st      <= '0;
            rkey    <= '0;
            din_l   <= '0;
            out_q   <= '0;
            mode_l  <= 1'b0;
            rnd     <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (key_load) key_reg <= key;
                    if (iv_load)  ctr     <= iv;
                    // in_ready excludes load cycles, so accept never overlaps a load.
                    if (accept) begin
                        mode_l <= mode;
                        din_l  <= bus.in_data;
                        st     <= (mode ? ctr : bus.in_data) ^ key_reg;
                        rkey   <= key_reg;
                        rnd    <= RW'(1);
                        if (mode) ctr <= (ctr & ~CMASK) | ((ctr + 128'd1) & CMASK);
                    end
                end
                ROUND: begin
                    st   <= rnd_out;
                    rkey <= nk;
                    rnd  <= rnd + RW'(1);
                    if (last) out_q <= mode_l ? (rnd_out ^ din_l) : rnd_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_ecb_ctr.sv
module tb_aes128_iter_ecb_ctr;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0, iv_load = 1'b0, mode = 1'b0;
    logic [127:0] key = '0, iv = '0;
    logic [127:0] ctr_value;
    logic         busy;

    aes128_iter_ecb_ctr_if bus();

    aes128_iter_ecb_ctr dut (
        .clk(clk), .rst(rst),
        .key_load(key_load), .key(key),
        .iv_load(iv_load), .iv(iv),
        .mode(mode),
        .bus(bus),
        .ctr_value(ctr_value),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] D3A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] E3A = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] D3B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] E3B = 128'h9806f66b7970fdff8617187bb9fffdff;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at time %0t", nm, $time);
    endtask

    // ---- reference AES, FIPS-197 as a byte matrix ----
    logic [7:0] sbt [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] q;
        q = '0;
        for (int i = 0; i < 8; i++) if (b[i]) q ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (q[i]) q ^= (16'h011b << (i - 8));
        return q[7:0];
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sbt[tw[23:16]], sbt[tw[15:8]], sbt[tw[7:0]], sbt[tw[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbt[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd == 10) s[r][c] = t[r][c];
                    else s[r][c] = gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c])
                                   ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    s[r][c] ^= w[4*rd+c][31-8*r -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---- cycle model: idle / running k edges since accept / holding ----
    int           m_phase = 0;
    int           m_k = 0;
    logic [127:0] m_key = '0, m_ctr = '0, m_out = '0, m_res = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_k = 0; m_key = '0; m_ctr = '0; m_out = '0;
            end else begin
                case (m_phase)
                    0: begin
                        if (bus.in_valid && !key_load && !iv_load) begin
                            m_res = mode ? (aes(m_key, m_ctr) ^ bus.in_data) : aes(m_key, bus.in_data);
                            if (mode) m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
                            m_k = 0;
                            m_phase = 1;
                        end
                        if (key_load) m_key = key;
                        if (iv_load)  m_ctr = iv;
                    end
                    1: begin
                        m_k++;
                        if (m_k == 10) begin m_out = m_res; m_phase = 2; end
                    end
                    default: if (bus.out_ready) m_phase = 0;
                endcase
            end
            #1;
            chk("in_ready",  128'(bus.in_ready),  128'(m_phase == 0 && !key_load && !iv_load));
            chk("out_valid", 128'(bus.out_valid), 128'(m_phase == 2));
            chk("busy",      128'(busy),          128'(m_phase != 0));
            chk("out_data",  bus.out_data, m_out);
            chk("ctr_value", ctr_value,    m_ctr);
        end
    end

    // ---- stimulus helpers (entered and left on a falling edge) ----
    task automatic load(input logic [127:0] k, input logic [127:0] v, input logic kl, input logic il);
        key = k; iv = v; key_load = kl; iv_load = il;
        @(negedge clk);
        key_load = 1'b0; iv_load = 1'b0;
    endtask

    task automatic send(input logic md, input logic [127:0] d, input int hold,
                        input bit early, input bit glitch, output logic [127:0] res);
        int t;
        res = '0;
        mode = md; bus.in_data = d; bus.in_valid = 1'b1;
        #1;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(negedge clk); #1; t++; end
        if (t >= 50) begin timeout("accept"); bus.in_valid = 1'b0; return; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = early;
        if (glitch) begin
            @(negedge clk); @(negedge clk);
            key = {4{$urandom()}}; iv = {4{$urandom()}};
            key_load = 1'b1; iv_load = 1'b1;
            @(negedge clk);
            key_load = 1'b0; iv_load = 1'b0;
        end
        t = 0;
        while (!bus.out_valid && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin timeout("out_valid"); bus.out_ready = 1'b0; return; end
        res = bus.out_data;
        if (!early) begin
            repeat (hold) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0]   inv, b, cst;
        logic [127:0] r, up;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbt[x] = b;
        end

        // known-answer vectors pin the reference model
        chk("model_c1",  aes(K1, P1), C1);
        chk("model_b",   aes(K2, P2), C2);
        chk("model_f51", aes(K2, IV3) ^ D3A, E3A);

        repeat (3) @(negedge clk);
        chk("rst_out_data",  bus.out_data, 128'h0);
        chk("rst_ctr",       ctr_value,    128'h0);
        chk("rst_busy",      128'(busy),          128'h0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // ECB known answers
        load(K1, '0, 1'b1, 1'b0);
        send(1'b0, P1, 0, 1'b0, 1'b0, r);
        chk("ecb_c1", r, C1);
        load(K2, '0, 1'b1, 1'b0);
        send(1'b0, P2, 0, 1'b0, 1'b0, r);
        chk("ecb_b", r, C2);

        // CTR known answers
        load('0, IV3, 1'b0, 1'b1);
        send(1'b1, D3A, 1, 1'b0, 1'b0, r);
        chk("ctr_blk1", r, E3A);
        send(1'b1, D3B, 0, 1'b1, 1'b0, r);
        chk("ctr_blk2", r, E3B);
        chk("ctr_final", ctr_value, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01);

        // long backpressure
        send(1'b0, P2, 20, 1'b0, 1'b0, r);
        chk("bp_data", r, C2);

        // counter wrap of the low 32 bits
        up = {4{$urandom()}};
        load('0, {up[127:32], 32'hffffffff}, 1'b0, 1'b1);
        send(1'b1, P1, 0, 1'b0, 1'b0, r);
        chk("wrap_ctr0", ctr_value, {up[127:32], 32'h00000000});
        send(1'b1, P2, 0, 1'b0, 1'b0, r);
        chk("wrap_out2", r, aes(K2, {up[127:32], 32'h00000000}) ^ P2);
        chk("wrap_ctr1", ctr_value, {up[127:32], 32'h00000001});

        // loads during the round sequence are ignored
        send(1'b0, P2, 0, 1'b0, 1'b1, r);
        chk("ldround_data", r, C2);
        send(1'b0, P1, 0, 1'b0, 1'b0, r);
        chk("ldround_key", r, aes(K2, P1));

        // reset in the middle of a block
        mode = 1'b0; bus.in_data = P1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  128'(busy),          128'h0);
        chk("mid_rst_ovld",  128'(bus.out_valid), 128'h0);
        chk("mid_rst_data",  bus.out_data,        128'h0);
        chk("mid_rst_ctr",   ctr_value,           128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(K1, '0, 1'b1, 1'b0);
        send(1'b0, P1, 0, 1'b0, 1'b0, r);
        chk("after_rst_c1", r, C1);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                load({4{$urandom()}}, {4{$urandom()}}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            send(1'($urandom_range(0, 1)), {4{$urandom()}}, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), r);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
